// File: rtl/adxl345_pkg.sv
// Shared definitions for the ADXL345 controller and sample assembler.
// Contents: register addresses, the expected device ID, the number of data
// bytes in one frame, and the packed X/Y/Z sample type.
package adxl345_pkg;

  localparam logic [7:0] DEVID       = 8'h00;
  localparam logic [7:0] POWER_CTL   = 8'h2D;
  localparam logic [7:0] DATA_FORMAT = 8'h31;
  localparam logic [7:0] INT_ENABLE  = 8'h2E;
  localparam logic [7:0] FIFO_CTL    = 8'h38;
  localparam logic [7:0] DATAX0      = 8'h32;
  localparam logic [7:0] DATAX1      = 8'h33;
  localparam logic [7:0] DATAY0      = 8'h34;
  localparam logic [7:0] DATAY1      = 8'h35;
  localparam logic [7:0] DATAZ0      = 8'h36;
  localparam logic [7:0] DATAZ1      = 8'h37;

  localparam logic [7:0] DEVID_VALUE = 8'hE5;
  localparam int         FRAME_BYTES = 6;

  typedef struct packed {
    logic signed [15:0] z;
    logic signed [15:0] y;
    logic signed [15:0] x;
  } adxl345_sample_t;

endpackage

// File: rtl/adxl345_axis_accumulator.sv
// Boxcar accumulator for one axis.
// Ports: sys_clk/reset (async, active-low); clear empties the accumulator;
// add_en adds value into it; avg is (acc + value) >>> AVG_LOG2, i.e. the
// block mean including the frame currently being presented, so the last
// frame of a block never has to be stored before it is averaged.
module adxl345_axis_accumulator
  import adxl345_pkg::*;
#(
  parameter int AVG_LOG2 = 0
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               add_en,
  input  logic signed [15:0] value,
  output logic signed [15:0] avg
);

  localparam int W = 16 + AVG_LOG2;

  logic signed [W-1:0] acc;
  logic signed [W-1:0] sum;

  // Size cast of a signed operand sign-extends.
  assign sum = acc + W'(value);
  assign avg = 16'(sum >>> AVG_LOG2);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset)      acc <= '0;
    else if (clear)  acc <= '0;
    else if (add_en) acc <= sum;
  end

endmodule

// File: rtl/adxl345_sample_assembler.sv
// Assembles DATAX0..DATAZ1 response bytes into signed X/Y/Z samples,
// optionally averages 2^AVG_LOG2 samples, and presents them on AXI-Stream.
// Ports: s_* response stream in (tdata[7:0] = byte, tuser = start of frame),
// m_* sample stream out ({Z,Y,X}, tlast tied 1), frame_errors = saturating
// count of framing errors. sys_clk domain, reset async active-low.
module adxl345_sample_assembler
  import adxl345_pkg::*;
#(
  parameter int AVG_LOG2      = 0,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic [15:0]              s_tdata,
  input  logic                     s_tuser,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  output logic [47:0]              m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [ERR_CNT_WIDTH-1:0] frame_errors
);

  localparam int              CW       = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0]   BLK_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [2:0]      IDX_LAST = 3'(FRAME_BYTES - 1);

  logic [2:0]               byte_idx;
  logic [7:0]               x_lo, x_hi, y_lo, y_hi, z_lo;
  logic [CW-1:0]            blk_cnt;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
  adxl345_sample_t          out_q, asm_s;
  logic                     out_vld;
  logic signed [15:0]       avg_x, avg_y, avg_z;

  logic [7:0] rx_byte;
  logic       accept, resync, stray, frame_done, last_frame, load, acc_add;
  logic       unused_hi;

  assign rx_byte   = s_tdata[7:0];
  assign unused_hi = ^s_tdata[15:8];

  assign last_frame = (blk_cnt == BLK_LAST);
  // Stall only the byte that would overwrite a sample still waiting downstream.
  assign s_tready   = !(out_vld && !m_tready && byte_idx == IDX_LAST && last_frame);
  assign accept     = s_tvalid && s_tready;
  assign resync     = accept && s_tuser && byte_idx != 3'd0;
  assign stray      = accept && !s_tuser && byte_idx == 3'd0;
  // tuser on index 5 is a resync, so a real completion needs tuser low.
  assign frame_done = accept && !s_tuser && byte_idx == IDX_LAST;
  assign load       = frame_done && last_frame;
  assign acc_add    = frame_done && !last_frame;

  always_comb begin
    asm_s   = '0;
    asm_s.x = {x_hi, x_lo};
    asm_s.y = {y_hi, y_lo};
    asm_s.z = {rx_byte, z_lo};
  end

  adxl345_axis_accumulator #(.AVG_LOG2(AVG_LOG2)) u_acc_x (
    .sys_clk(sys_clk), .reset(reset), .clear(load), .add_en(acc_add),
    .value(asm_s.x), .avg(avg_x));
  adxl345_axis_accumulator #(.AVG_LOG2(AVG_LOG2)) u_acc_y (
    .sys_clk(sys_clk), .reset(reset), .clear(load), .add_en(acc_add),
    .value(asm_s.y), .avg(avg_y));
  adxl345_axis_accumulator #(.AVG_LOG2(AVG_LOG2)) u_acc_z (
    .sys_clk(sys_clk), .reset(reset), .clear(load), .add_en(acc_add),
    .value(asm_s.z), .avg(avg_z));

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= '0;
      x_lo <= '0; x_hi <= '0; y_lo <= '0; y_hi <= '0; z_lo <= '0;
    end else if (accept) begin
      if (resync) begin
        x_lo     <= rx_byte;
        byte_idx <= 3'd1;
      end else if (!stray) begin
        case (byte_idx)
          3'd0:    x_lo <= rx_byte;
          3'd1:    x_hi <= rx_byte;
          3'd2:    y_lo <= rx_byte;
          3'd3:    y_hi <= rx_byte;
          3'd4:    z_lo <= rx_byte;
          default: ;
        endcase
        byte_idx <= (byte_idx == IDX_LAST) ? 3'd0 : byte_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset)          blk_cnt <= '0;
    else if (load)       blk_cnt <= '0;
    else if (frame_done) blk_cnt <= blk_cnt + CW'(1);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset)
      err_cnt <= '0;
    else if ((resync || stray) && err_cnt != {ERR_CNT_WIDTH{1'b1}})
      err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      out_vld <= 1'b0;
    end else if (load) begin
      out_q   <= '{z: avg_z, y: avg_y, x: avg_x};
      out_vld <= 1'b1;
    end else if (m_tready) begin
      out_vld <= 1'b0;
    end
  end

  assign m_tdata      = out_q;
  assign m_tvalid     = out_vld;
  assign m_tlast      = 1'b1;
  assign frame_errors = err_cnt;

endmodule

// File: tb/tb_adxl345_sample_assembler.sv
module tb_adxl345_sample_assembler;

  logic        sys_clk = 1'b0;
  logic        reset;
  // index 0: AVG_LOG2=0 instance, index 1: AVG_LOG2=2 instance
  logic [15:0] s_tdata0, s_tdata1;
  logic        s_tuser0, s_tuser1, s_tvalid0, s_tvalid1, s_tready0, s_tready1;
  logic [47:0] m_tdata0, m_tdata1;
  logic        m_tvalid0, m_tvalid1, m_tready0, m_tready1, m_tlast0, m_tlast1;
  logic [7:0]  frame_errors0, frame_errors1;

  always #5 sys_clk = ~sys_clk;

  adxl345_sample_assembler #(.AVG_LOG2(0), .ERR_CNT_WIDTH(8)) dut0 (
    .sys_clk(sys_clk), .reset(reset), .s_tdata(s_tdata0), .s_tuser(s_tuser0),
    .s_tvalid(s_tvalid0), .s_tready(s_tready0), .m_tdata(m_tdata0),
    .m_tvalid(m_tvalid0), .m_tready(m_tready0), .m_tlast(m_tlast0),
    .frame_errors(frame_errors0));

  adxl345_sample_assembler #(.AVG_LOG2(2), .ERR_CNT_WIDTH(8)) dut1 (
    .sys_clk(sys_clk), .reset(reset), .s_tdata(s_tdata1), .s_tuser(s_tuser1),
    .s_tvalid(s_tvalid1), .s_tready(s_tready1), .m_tdata(m_tdata1),
    .m_tvalid(m_tvalid1), .m_tready(m_tready1), .m_tlast(m_tlast1),
    .frame_errors(frame_errors1));

  int errors = 0;
  int checks = 0;
  bit rnd_rdy = 0;

  // Reference model state (per instance)
  int          LOG2[2] = '{0, 2};
  int          m_pos[2];
  logic [7:0]  m_buf[2][6];
  int          m_sum[2][3];
  int          m_n[2];
  int          m_err[2];
  logic [47:0] q0[$], q1[$];
  bit          held_v[2];
  logic [47:0] held_d[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_tv(input int d);
    return d == 0 ? m_tvalid0 : m_tvalid1;
  endfunction
  function automatic logic get_tr(input int d);
    return d == 0 ? m_tready0 : m_tready1;
  endfunction
  function automatic logic [47:0] get_td(input int d);
    return d == 0 ? m_tdata0 : m_tdata1;
  endfunction
  function automatic logic get_tl(input int d);
    return d == 0 ? m_tlast0 : m_tlast1;
  endfunction
  function automatic logic [7:0] get_fe(input int d);
    return d == 0 ? frame_errors0 : frame_errors1;
  endfunction

  function automatic int floor_div(input int a, input int n);
    return (a >= 0) ? a / n : -((-a + n - 1) / n);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pos[d] = 0; m_n[d] = 0; m_err[d] = 0; held_v[d] = 0;
      for (int a = 0; a < 3; a++) m_sum[d][a] = 0;
    end
    q0.delete(); q1.delete();
  endtask

  task automatic model_err(input int d);
    if (m_err[d] < 255) m_err[d]++;
  endtask

  // Applies the framing rules to one accepted byte; reports whether a sample
  // is produced and queues its expected value.
  task automatic model_accept(input int d, input logic [7:0] b, input logic u, output bit prod);
    logic signed [15:0] w;
    logic [15:0] f[3];
    int n;
    prod = 0;
    if (u && m_pos[d] != 0) begin
      model_err(d);
      m_buf[d][0] = b;
      m_pos[d] = 1;
    end else if (!u && m_pos[d] == 0) begin
      model_err(d);
    end else begin
      m_buf[d][m_pos[d]] = b;
      m_pos[d]++;
      if (m_pos[d] == 6) begin
        m_pos[d] = 0;
        for (int a = 0; a < 3; a++) begin
          w = {m_buf[d][2*a+1], m_buf[d][2*a]};
          m_sum[d][a] += int'(w);
        end
        m_n[d]++;
        n = 1 << LOG2[d];
        if (m_n[d] == n) begin
          for (int a = 0; a < 3; a++) begin
            f[a] = 16'(floor_div(m_sum[d][a], n));
            m_sum[d][a] = 0;
          end
          m_n[d] = 0;
          if (d == 0) q0.push_back({f[2], f[1], f[0]});
          else        q1.push_back({f[2], f[1], f[0]});
          prod = 1;
        end
      end
    end
  endtask

  // Inputs change on negedge, s_tready is read 1 after, DUT acts on posedge.
  task automatic send(input int d, input logic [7:0] b, input logic u);
    logic [7:0] hi;
    bit acc, prod;
    hi = 8'($urandom);
    acc = 0;
    @(negedge sys_clk);
    if (d == 0) begin s_tdata0 = {hi, b}; s_tuser0 = u; s_tvalid0 = 1; end
    else        begin s_tdata1 = {hi, b}; s_tuser1 = u; s_tvalid1 = 1; end
    for (int n = 0; n < 200; n++) begin
      #1 acc = (d == 0) ? s_tready0 : s_tready1;
      @(posedge sys_clk);
      if (acc) break;
      @(negedge sys_clk);
    end
    if (acc) begin
      model_accept(d, b, u, prod);
      #1;
      if (prod) chk("latency_tvalid", 64'(get_tv(d)), 64'd1);
    end else begin
      errors++; checks++;
      $display("FAIL accept_timeout: dut%0d byte %0h not accepted", d, b);
      #1;
    end
    if (d == 0) s_tvalid0 = 0; else s_tvalid1 = 0;
  endtask

  task automatic send_frame(input int d, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    send(d, x[7:0], 1); send(d, x[15:8], 0);
    send(d, y[7:0], 0); send(d, y[15:8], 0);
    send(d, z[7:0], 0); send(d, z[15:8], 0);
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge sys_clk);
      #2;
      if (reset) begin
        for (int d = 0; d < 2; d++) begin
          if (get_tv(d) && !get_tr(d)) begin
            if (held_v[d]) chk("hold_stable", 64'(get_td(d)), 64'(held_d[d]));
            held_v[d] = 1; held_d[d] = get_td(d);
          end else held_v[d] = 0;
          if (get_tv(d) && get_tr(d)) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
              errors++; checks++;
              $display("FAIL unexpected_beat: dut%0d data %0h", d, get_td(d));
            end else begin
              chk(d == 0 ? "sample_avg0" : "sample_avg2", 64'(get_td(d)),
                  64'(d == 0 ? q0.pop_front() : q1.pop_front()));
              chk("tlast", 64'(get_tl(d)), 64'd1);
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      if (rnd_rdy) begin
        m_tready0 = ($urandom_range(0, 3) != 0);
        m_tready1 = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic check_errs(input string name);
    chk({name, "_fe0"}, 64'(frame_errors0), 64'(m_err[0]));
    chk({name, "_fe1"}, 64'(frame_errors1), 64'(m_err[1]));
  endtask

  initial begin
    reset = 0;
    s_tdata0 = 0; s_tuser0 = 0; s_tvalid0 = 0; m_tready0 = 1;
    s_tdata1 = 0; s_tuser1 = 0; s_tvalid1 = 0; m_tready1 = 1;
    model_reset();
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_tvalid", 64'(get_tv(d)), 64'd0);
      chk("rst_tdata", 64'(get_td(d)), 64'd0);
      chk("rst_fe", 64'(get_fe(d)), 64'd0);
    end
    chk("rst_tready0", 64'(s_tready0), 64'd1);
    chk("rst_tready1", 64'(s_tready1), 64'd1);
    repeat (2) @(negedge sys_clk);
    reset = 1;

    // Basic frame, pass-through
    send(0, 8'h34, 1); send(0, 8'h12, 0); send(0, 8'hFF, 0);
    send(0, 8'hFF, 0); send(0, 8'h00, 0); send(0, 8'h01, 0);
    repeat (2) @(negedge sys_clk);
    check_errs("t1");

    // Averaging block of four
    send_frame(1, 16'h0001, 16'hFFFF, 16'h0000);
    chk("avg_no_beat1", 64'(m_tvalid1), 64'd0);
    send_frame(1, 16'h0002, 16'hFFFF, 16'h0000);
    chk("avg_no_beat2", 64'(m_tvalid1), 64'd0);
    send_frame(1, 16'h0003, 16'hFFFF, 16'h0000);
    chk("avg_no_beat3", 64'(m_tvalid1), 64'd0);
    send_frame(1, 16'hFFFF, 16'hFFFE, 16'h0000);
    repeat (2) @(negedge sys_clk);

    // Backpressure: second frame stalls on its last byte
    m_tready0 = 0;
    send_frame(0, 16'h1111, 16'h2222, 16'h3333);
    send(0, 8'h44, 1); send(0, 8'hC4, 0); send(0, 8'h55, 0);
    send(0, 8'hA5, 0); send(0, 8'h66, 0);
    fork
      send(0, 8'h96, 0);
      begin
        repeat (4) begin
          @(negedge sys_clk); #1;
          chk("stall_tready", 64'(s_tready0), 64'd0);
        end
        @(negedge sys_clk);
        m_tready0 = 1;
      end
    join
    repeat (3) @(negedge sys_clk);
    chk("t3_drained", 64'(q0.size()), 64'd0);

    // Truncated frame then resync, then strays
    send(0, 8'h11, 1); send(0, 8'h22, 0); send(0, 8'h33, 0); send(0, 8'h44, 0);
    send_frame(0, 16'h0000, 16'h0010, 16'h0020);
    repeat (2) @(negedge sys_clk);
    check_errs("t4a");
    repeat (3) send(0, 8'($urandom), 0);
    repeat (2) @(negedge sys_clk);
    check_errs("t4b");
    chk("t4_no_beat", 64'(q0.size()), 64'd0);

    // Reset mid-frame
    send(0, 8'h01, 1); send(0, 8'h02, 0); send(0, 8'h03, 0);
    send(1, 8'h01, 1); send(1, 8'h02, 0); send(1, 8'h03, 0);
    @(negedge sys_clk);
    reset = 0;
    #1;
    chk("mid_rst_tvalid0", 64'(m_tvalid0), 64'd0);
    chk("mid_rst_fe0", 64'(frame_errors0), 64'd0);
    model_reset();
    repeat (2) @(negedge sys_clk);
    reset = 1;
    send_frame(0, 16'h8001, 16'h7FFE, 16'h00A5);
    repeat (2) @(negedge sys_clk);
    check_errs("t5");

    // Error counter saturation
    repeat (300) send(0, 8'($urandom), 0);
    repeat (2) @(negedge sys_clk);
    chk("sat_fe0", 64'(frame_errors0), 64'hFF);
    check_errs("t6");

    // Randomized traffic with random backpressure
    rnd_rdy = 1;
    for (int f = 0; f < 80; f++) begin
      int d, r;
      d = f % 2;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        repeat ($urandom_range(1, 5)) send(d, 8'($urandom), 0);
      end else if (r == 1) begin
        send(d, 8'($urandom), 1);
        send(d, 8'($urandom), 0);
      end else begin
        send_frame(d, 16'($urandom), 16'($urandom), 16'($urandom));
      end
    end
    @(negedge sys_clk);
    rnd_rdy = 0;
    m_tready0 = 1; m_tready1 = 1;
    for (int n = 0; n < 50 && (q0.size() != 0 || q1.size() != 0); n++)
      @(negedge sys_clk);
    repeat (2) @(negedge sys_clk);
    chk("final_q0_empty", 64'(q0.size()), 64'd0);
    chk("final_q1_empty", 64'(q1.size()), 64'd0);
    check_errs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adxl345_sample_assembler.md
Name: adxl345_sample_assembler

Overview:
Downstream consumer of the adxl345 controller's SPI response stream. It takes one register-read response word per byte, in the order DATAX0, DATAX1, DATAY0, DATAY1, DATAZ0, DATAZ1, and assembles each 6-byte frame into one signed X/Y/Z sample. It optionally averages 2^AVG_LOG2 consecutive samples (boxcar, decimating) and emits the result on an AXI-Stream source for the rest of the design.

Parameters:
AVG_LOG2, 0, log2 of the number of samples averaged per output beat; legal range 0..4; 0 means pass-through with no averaging.
ERR_CNT_WIDTH, 8, width of the saturating frame-error counter.

Ports:
sys_clk  input  1  system clock; all logic is in this domain.
reset  input  1  asynchronous, active-low reset (asserted at 0).
s_tdata  input  16  response word; bits [7:0] carry the register byte; bits [15:8] are ignored.
s_tuser  input  1  start-of-frame marker; set by the sequencer on the DATAX0 read response.
s_tvalid  input  1  response word valid.
s_tready  output  1  response word accepted.
m_tdata  output  48  sample {Z[15:0], Y[15:0], X[15:0]}, each field two's complement.
m_tvalid  output  1  sample valid.
m_tready  input  1  downstream ready.
m_tlast  output  1  constant 1; every beat is one sample.
frame_errors  output  ERR_CNT_WIDTH  saturating count of framing errors.

Behaviour:
- Reset (async, active-low): m_tvalid=0, m_tdata=0, byte index=0, accumulators=0, block counter=0, frame_errors=0. Any partial frame is discarded. s_tready comes out of reset high.
- Beat acceptance: a beat is accepted on a rising sys_clk when s_tvalid and s_tready are both 1. The byte index (0..5) advances only on an accepted beat.
- Byte capture: index 0/2/4 capture the low byte of X/Y/Z. Index 1/3/5 capture the high byte. Each axis word is {hi, lo} and is treated as signed.
- Framing rules:
  - s_tuser=1 with index≠0: frame_errors increments, the partial frame is dropped, the byte is taken as X0, and the index becomes 1.
  - s_tuser=0 with index=0: frame_errors increments, the byte is discarded, and the index stays 0.
  - frame_errors saturates at all-ones and never wraps.
- Frame completion: accepting index 5 completes a frame and the index returns to 0.
  - AVG_LOG2=0: the assembled sample is loaded directly into the output register.
  - AVG_LOG2>0: each axis is added into a signed accumulator of width 16+AVG_LOG2, which cannot overflow. When the block counter reaches 2^AVG_LOG2−1, the output field is acc>>>AVG_LOG2 (arithmetic shift, rounds toward −inf, result taken as 16 bits). The accumulators then clear and the block counter returns to 0.
- Latency: m_tvalid rises on the cycle after the accepted beat that completes an output sample.
- Output register: single entry.
  - A beat transfers when m_tvalid and m_tready are both 1. m_tvalid falls the next cycle unless a new sample loads on the same edge.
  - m_tdata is held stable while m_tvalid=1 and m_tready=0.
- Backpressure:
  - s_tready = !(m_tvalid && !m_tready && completing_beat), where completing_beat means index=5 and it is the last frame of the averaging block.
  - Non-completing bytes are always accepted.
  - A simultaneous pop and load on the same edge is legal and keeps m_tvalid=1 with the new data.
- s_tdata[15:8] has no effect on any output.

Decomposition:
- adxl345_pkg holds:
  - register address localparams: DEVID, POWER_CTL, DATA_FORMAT, INT_ENABLE, FIFO_CTL, DATAX0..DATAZ1;
  - DEVID_VALUE = 8'hE5;
  - FRAME_BYTES = 6;
  - typedef adxl345_sample_t = struct packed {logic signed [15:0] z, y, x;}.
- The controller imports the same package.
- One sub-module, adxl345_axis_accumulator: parameter AVG_LOG2, with inputs clear, add_en, and a signed 16-bit value, and a signed 16-bit averaged result output. It is instantiated three times, once each for X, Y and Z.

Test Plan:
1. AVG_LOG2=0, m_tready=1; bytes 34,12,FF,FF,00,01 with tuser=1 on the first byte -> one beat, m_tdata=48'h0100_FFFF_1234, m_tlast=1, one cycle after the 6th accept; frame_errors=0.
2. AVG_LOG2=2; four frames with X=1,2,3,−1 and Y=−1,−1,−1,−2, Z=0 -> a single beat with X=16'h0001, Y=16'hFFFE, Z=0; no beat after frames 1–3.
3. AVG_LOG2=0, m_tready=0 after the first sample; send a second full frame -> bytes 0–4 are accepted, s_tready=0 on byte 5 until m_tready=1; the first sample is held stable, then the second is delivered; no data is lost.
4. A frame truncated after Y1, then a new tuser=1 frame 00,00,10,00,20,00 -> frame_errors=1, output {16'h0020,16'h0010,16'h0000}. Three tuser=0 stray bytes at index 0 -> frame_errors=4 with no output.
5. Assert reset (0) mid-frame after 3 bytes, then release and send a full frame -> no output from the partial frame, m_tvalid=0 during reset, and a correct sample from the new frame.
6. ERR_CNT_WIDTH=8; 300 stray tuser=0 bytes -> frame_errors stays at 8'hFF.
